// File: rtl/fifo_uart_drain.sv
// Drains 32-bit words from a FIFO and sends each as a 5-byte UART 8N1 frame:
// a sync byte followed by the word MSB byte first, each byte LSB-first.
module fifo_uart_drain #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        i_clk,
  input  logic        _mrst,
  input  logic        i_enable,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_q,
  output logic        fifo_rdreq,
  output logic        o_tx,
  output logic        o_busy,
  output logic [15:0] o_words_sent
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  localparam logic [15:0] BIT_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BYTE  = 3'd4;
  localparam logic [2:0]  LAST_BIT   = 3'd7;

  state_t      state_reg, state_next;
  logic [31:0] word_reg, word_next;
  logic [2:0]  byte_idx_reg, byte_idx_next;
  logic [2:0]  bit_idx_reg, bit_idx_next;
  logic [15:0] bit_cnt_reg, bit_cnt_next;
  logic [15:0] words_sent_reg, words_sent_next;
  logic        tx_reg, tx_next;
  // Holds off the first fetch until one full clock after reset release.
  logic        armed_reg;

  logic [7:0]  frame_byte [8];

  genvar gi;
  assign frame_byte[0] = SYNC_BYTE;
  for (gi = 1; gi < 5; gi++) begin : g_word_bytes
    assign frame_byte[gi] = word_next[39-8*gi -: 8];
  end
  for (gi = 5; gi < 8; gi++) begin : g_pad_bytes
    assign frame_byte[gi] = 8'hFF;
  end

  always_ff @(posedge i_clk or negedge _mrst) begin
    if (!_mrst) begin
      state_reg      <= IDLE;
      word_reg       <= '0;
      byte_idx_reg   <= '0;
      bit_idx_reg    <= '0;
      bit_cnt_reg    <= '0;
      words_sent_reg <= '0;
      tx_reg         <= 1'b1;
      armed_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      word_reg       <= word_next;
      byte_idx_reg   <= byte_idx_next;
      bit_idx_reg    <= bit_idx_next;
      bit_cnt_reg    <= bit_cnt_next;
      words_sent_reg <= words_sent_next;
      tx_reg         <= tx_next;
      armed_reg      <= 1'b1;
    end
  end

  always_comb begin
    state_next      = state_reg;
    word_next       = word_reg;
    byte_idx_next   = byte_idx_reg;
    bit_idx_next    = bit_idx_reg;
    bit_cnt_next    = bit_cnt_reg;
    words_sent_next = words_sent_reg;

    case (state_reg)
      IDLE: begin
        if (armed_reg && i_enable && !fifo_empty) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        state_next = LATCH;
      end
      LATCH: begin
        word_next     = fifo_q;
        byte_idx_next = '0;
        bit_idx_next  = '0;
        bit_cnt_next  = BIT_RELOAD;
        state_next    = START;
      end
      START: begin
        if (bit_cnt_reg == '0) begin
          bit_cnt_next = BIT_RELOAD;
          bit_idx_next = '0;
          state_next   = DATA;
        end else begin
          bit_cnt_next = bit_cnt_reg - 16'd1;
        end
      end
      DATA: begin
        if (bit_cnt_reg == '0) begin
          bit_cnt_next = BIT_RELOAD;
          if (bit_idx_reg == LAST_BIT) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          bit_cnt_next = bit_cnt_reg - 16'd1;
        end
      end
      STOP: begin
        if (bit_cnt_reg == '0) begin
          if (byte_idx_reg == LAST_BYTE) begin
            bit_cnt_next    = '0;
            words_sent_next = words_sent_reg + 16'd1;
            state_next      = IDLE;
          end else begin
            bit_cnt_next  = BIT_RELOAD;
            byte_idx_next = byte_idx_reg + 3'd1;
            state_next    = START;
          end
        end else begin
          bit_cnt_next = bit_cnt_reg - 16'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Line level is decided from the next state so the flop output lines up with the state.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = frame_byte[byte_idx_next][bit_idx_next];
      default: tx_next = 1'b1;
    endcase
  end

  assign fifo_rdreq   = (state_reg == FETCH);
  assign o_busy       = (state_reg != IDLE);
  assign o_tx         = tx_reg;
  assign o_words_sent = words_sent_reg;

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Directed bench for fifo_uart_drain at 4 clocks per bit, with a small FIFO model
// feeding fifo_q one cycle after each read strobe.
`timescale 1ns/1ps
module tb_fifo_uart_drain;

  localparam int CPB        = 4;
  localparam int FRAME_BUSY = 50*CPB + 2;  // FETCH + LATCH + 50 bit periods
  localparam int FRAME_GAP  = 50*CPB + 3;  // plus the one IDLE cycle between frames

  logic        i_clk = 1'b0;
  logic        mrst = 1'b0;
  logic        i_enable = 1'b0;
  logic        fifo_empty;
  logic [31:0] fifo_q = '0;
  logic        fifo_rdreq;
  logic        o_tx;
  logic        o_busy;
  logic [15:0] o_words_sent;

  logic [31:0] fifo_mem [16];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          cyc_cnt = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  fifo_uart_drain #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .i_clk       (i_clk),
    ._mrst       (mrst),
    .i_enable    (i_enable),
    .fifo_empty  (fifo_empty),
    .fifo_q      (fifo_q),
    .fifo_rdreq  (fifo_rdreq),
    .o_tx        (o_tx),
    .o_busy      (o_busy),
    .o_words_sent(o_words_sent)
  );

  always #5 i_clk = ~i_clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge i_clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (fifo_rdreq) begin
      fifo_q <= fifo_mem[rd_ptr % 16];
      rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    $display("check %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic [31:0] w);
    fifo_mem[wr_ptr % 16] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    mrst = 1'b0;
    i_enable = 1'b0;
    repeat (2) @(negedge i_clk);
    wr_ptr = rd_ptr;
  endtask

  function automatic logic [7:0] frame_exp(input logic [31:0] w, input int j);
    logic [39:0] f;
    f = {8'hA5, w};
    return f[39-8*j -: 8];
  endfunction

  task automatic wait_rdreq(input string tag, output int at_cyc);
    int i = 0;
    do begin
      @(negedge i_clk);
      i++;
    end while (!fifo_rdreq && i < 2000);
    at_cyc = cyc_cnt;
    check({tag, "_rdreq_seen"}, 32'(fifo_rdreq), 32'd1);
  endtask

  // Called at the negedge of the FETCH cycle; walks the whole frame.
  task automatic capture_frame(input string tag, input logic [31:0] w, input int drop_at);
    int tx_errs = 0;
    int busy_cnt = 0;
    int rd_extra = 0;
    int k = 0;
    logic [9:0] rx = '0;
    logic [7:0] exp_b;
    logic       exp_bit;
    busy_cnt += int'(o_busy);
    if (o_tx !== 1'b1) tx_errs++;
    @(negedge i_clk);
    busy_cnt += int'(o_busy);
    if (o_tx !== 1'b1) tx_errs++;
    if (fifo_rdreq) rd_extra++;
    for (int j = 0; j < 5; j++) begin
      exp_b = frame_exp(w, j);
      for (int b = 0; b < 10; b++) begin
        exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp_b[b-1];
        for (int c = 0; c < CPB; c++) begin
          @(negedge i_clk);
          k++;
          if (k == drop_at) i_enable = 1'b0;
          busy_cnt += int'(o_busy);
          if (fifo_rdreq) rd_extra++;
          if (o_tx !== exp_bit) tx_errs++;
          if (c == 2) rx[b] = o_tx;
        end
      end
      check($sformatf("%s_byte%0d", tag, j), {24'd0, rx[8:1]}, {24'd0, exp_b});
    end
    @(negedge i_clk);
    check({tag, "_idle_after"}, {30'd0, o_busy, o_tx}, 32'd1);
    check({tag, "_tx_bit_errs"}, 32'(tx_errs), 32'd0);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(FRAME_BUSY));
    check({tag, "_extra_rdreq"}, 32'(rd_extra), 32'd0);
  endtask

  initial begin
    int t0, t1, t2;
    int bad_a, bad_b, bad_c;
    logic [31:0] words3 [3];
    words3[0] = 32'h00FF0F0F;
    words3[1] = 32'hDEADBEEF;
    words3[2] = 32'h80000001;

    // Reset state
    repeat (3) @(negedge i_clk);
    check("rst_tx", 32'(o_tx), 32'd1);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_rdreq", 32'(fifo_rdreq), 32'd0);
    check("rst_words", 32'(o_words_sent), 32'd0);

    // Empty FIFO with enable high: nothing moves
    mrst = 1'b1;
    i_enable = 1'b1;
    bad_a = 0; bad_b = 0;
    repeat (1000) begin
      @(negedge i_clk);
      if (fifo_rdreq) bad_a++;
      if (o_tx !== 1'b1) bad_b++;
    end
    check("empty_rdreq_count", 32'(bad_a), 32'd0);
    check("empty_tx_low_count", 32'(bad_b), 32'd0);

    // Single word, including first-fetch latency after reset release
    do_reset();
    push(32'h12345678);
    i_enable = 1'b1;
    mrst = 1'b1;
    @(negedge i_clk);
    check("release_edge1_rdreq", 32'(fifo_rdreq), 32'd0);
    wait_rdreq("one", t0);
    capture_frame("one", 32'h12345678, -1);
    check("one_words", 32'(o_words_sent), 32'd1);
    bad_a = 0;
    repeat (20) begin
      @(negedge i_clk);
      if (fifo_rdreq) bad_a++;
    end
    check("one_no_more_rdreq", 32'(bad_a), 32'd0);

    // Three words back to back
    do_reset();
    for (int i = 0; i < 3; i++) push(words3[i]);
    i_enable = 1'b1;
    mrst = 1'b1;
    wait_rdreq("three_f0", t0);
    capture_frame("three_f0", words3[0], -1);
    wait_rdreq("three_f1", t1);
    capture_frame("three_f1", words3[1], -1);
    wait_rdreq("three_f2", t2);
    capture_frame("three_f2", words3[2], -1);
    check("three_gap01", 32'(t1 - t0), 32'(FRAME_GAP));
    check("three_gap12", 32'(t2 - t1), 32'(FRAME_GAP));
    check("three_words", 32'(o_words_sent), 32'd3);

    // Enable dropped mid-frame
    do_reset();
    push(32'hCAFE0193);
    push(32'h0BADF00D);
    i_enable = 1'b1;
    mrst = 1'b1;
    wait_rdreq("drop", t0);
    capture_frame("drop", 32'hCAFE0193, 30);
    bad_a = 0;
    repeat (300) begin
      @(negedge i_clk);
      if (fifo_rdreq) bad_a++;
    end
    check("drop_no_rdreq", 32'(bad_a), 32'd0);
    check("drop_words", 32'(o_words_sent), 32'd1);

    // Reset in the middle of the sync byte
    do_reset();
    push(32'h55AA55AA);
    i_enable = 1'b1;
    mrst = 1'b1;
    wait_rdreq("midrst", t0);
    repeat (10) @(negedge i_clk);
    check("midrst_tx_before", 32'(o_tx), 32'd0);
    mrst = 1'b0;
    #1;
    check("midrst_tx_now", 32'(o_tx), 32'd1);
    check("midrst_busy_now", 32'(o_busy), 32'd0);
    check("midrst_rdreq_now", 32'(fifo_rdreq), 32'd0);
    @(negedge i_clk);
    mrst = 1'b1;
    bad_a = 0; bad_b = 0; bad_c = 0;
    repeat (10) begin
      @(negedge i_clk);
      if (o_busy) bad_a++;
      if (fifo_rdreq) bad_b++;
      if (o_words_sent != 16'd0) bad_c++;
    end
    check("midrst_busy_after", 32'(bad_a), 32'd0);
    check("midrst_rdreq_after", 32'(bad_b), 32'd0);
    check("midrst_words_after", 32'(bad_c), 32'd0);

    // Word counter wrap
    do_reset();
    i_enable = 1'b1;
    mrst = 1'b1;
    @(negedge i_clk);
    force dut.words_sent_reg = 16'hFFFF;
    @(negedge i_clk);
    release dut.words_sent_reg;
    @(negedge i_clk);
    check("wrap_preload", 32'(o_words_sent), 32'h0000FFFF);
    push(32'hA5A5A5A5);
    wait_rdreq("wrap", t0);
    capture_frame("wrap", 32'hA5A5A5A5, -1);
    check("wrap_words", 32'(o_words_sent), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
